// File: rtl/arc4_pkg.sv
// arc4_pkg: shared definitions for the ARC4 encrypt and decrypt paths.
//   - arc4_state_e : controller states (IDLE, INIT, KSA_*, LEN, PRGA_*, DROP, DONE)
//   - S_DEPTH, KSA_CYCLES_PER_I : S memory depth and fixed KSA cost per index
//   - keybyte()    : selects key byte (idx mod nbytes) from a big-endian key
//                    that is right-aligned in a MAX_KEY_BYTES-wide vector
package arc4_pkg;

    localparam int S_DEPTH          = 256;
    localparam int KSA_CYCLES_PER_I = 6;
    localparam int MAX_KEY_BYTES    = 32;

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA_RDI,
        ST_KSA_WAITI,
        ST_KSA_RDJ,
        ST_KSA_WAITJ,
        ST_KSA_WRI,
        ST_KSA_WRJ,
        ST_KSA_FIN,
        ST_KSA_RUN,
        ST_LEN_RD,
        ST_LEN_WAIT,
        ST_LEN_WR,
        ST_PRGA_RDI,
        ST_PRGA_WAITI,
        ST_PRGA_RDJ,
        ST_PRGA_WAITJ,
        ST_PRGA_WRI,
        ST_PRGA_WRJ,
        ST_PRGA_RDPAD,
        ST_PRGA_WAITPAD,
        ST_PRGA_XOR,
        ST_DROP,
        ST_DONE
    } arc4_state_e;

    // Key byte 0 is the most significant byte of the nbytes-wide key.
    function automatic logic [7:0] keybyte(input logic [8*MAX_KEY_BYTES-1:0] key,
                                           input int unsigned              nbytes,
                                           input logic [7:0]               idx);
        int unsigned k_idx;
        k_idx = 32'(idx) % nbytes;
        return 8'(key >> (32'd8 * (nbytes - 32'd1 - k_idx)));
    endfunction

endpackage

// File: rtl/arc4_ksa.sv
// arc4_ksa: fills S with the identity permutation (256 cycles) and then runs
// the ARC4 key schedule, 6 cycles per index (read s[i], wait, read s[j], wait,
// write s[i], write s[j]). The final S write is presented in ST_KSA_FIN, so
// when rdy returns high S is fully scheduled.
// Ports: clk, rst_n (async active-low), en/rdy start handshake (key latched on
// en && rdy), key (big-endian), s_addr/s_wrdata/s_wren/s_rddata S memory port
// (read data one cycle after the address is presented). Outputs are registered
// and idle at zero.
module arc4_ksa
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             s_addr,
    output logic [7:0]             s_wrdata,
    output logic                   s_wren,
    input  logic [7:0]             s_rddata
);

    arc4_state_e                state_q, state_d;
    logic [7:0]                 i_q, i_d, j_q, j_d, si_q, si_d;
    logic [8*KEY_BYTES-1:0]     key_q, key_d;
    logic [7:0]                 s_addr_q, s_addr_d, s_wrdata_q, s_wrdata_d;
    logic                       s_wren_q, s_wren_d, rdy_q, rdy_d;
    logic [8*MAX_KEY_BYTES-1:0] key_ext_s;
    logic [7:0]                 j_new_s;

    assign key_ext_s = {{(8*(MAX_KEY_BYTES-KEY_BYTES)){1'b0}}, key_q};
    assign j_new_s   = j_q + s_rddata + keybyte(key_ext_s, KEY_BYTES, i_q);

    // Next-state and S-port command logic for init + key schedule.
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        si_d       = si_q;
        key_d      = key_q;
        s_addr_d   = 8'h00;
        s_wrdata_d = 8'h00;
        s_wren_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    key_d   = key;
                    i_d     = 8'h00;
                    j_d     = 8'h00;
                    state_d = ST_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INIT: begin
                s_addr_d   = i_q;
                s_wrdata_d = i_q;
                s_wren_d   = 1'b1;
                i_d        = i_q + 8'd1;
                if (i_q == 8'(S_DEPTH - 1)) begin
                    state_d = ST_KSA_RDI;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_KSA_RDI: begin
                s_addr_d = i_q;
                state_d  = ST_KSA_WAITI;
            end
            ST_KSA_WAITI: state_d = ST_KSA_RDJ;
            ST_KSA_RDJ: begin
                si_d     = s_rddata;
                j_d      = j_new_s;
                s_addr_d = j_new_s;
                state_d  = ST_KSA_WAITJ;
            end
            ST_KSA_WAITJ: state_d = ST_KSA_WRI;
            ST_KSA_WRI: begin
                // s_rddata holds old s[j] here
                s_addr_d   = i_q;
                s_wrdata_d = s_rddata;
                s_wren_d   = 1'b1;
                state_d    = ST_KSA_WRJ;
            end
            ST_KSA_WRJ: begin
                s_addr_d   = j_q;
                s_wrdata_d = si_q;
                s_wren_d   = 1'b1;
                i_d        = i_q + 8'd1;
                if (i_q == 8'(S_DEPTH - 1)) begin
                    state_d = ST_KSA_FIN;
                end else begin
                    state_d = ST_KSA_RDI;
                end
            end
            ST_KSA_FIN: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        rdy_d = (state_d == ST_IDLE);
    end

    // State and registered S-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            i_q        <= 8'h00;
            j_q        <= 8'h00;
            si_q       <= 8'h00;
            key_q      <= '0;
            s_addr_q   <= 8'h00;
            s_wrdata_q <= 8'h00;
            s_wren_q   <= 1'b0;
            rdy_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            si_q       <= si_d;
            key_q      <= key_d;
            s_addr_q   <= s_addr_d;
            s_wrdata_q <= s_wrdata_d;
            s_wren_q   <= s_wren_d;
            rdy_q      <= rdy_d;
        end
    end

    assign rdy      = rdy_q;
    assign s_addr   = s_addr_q;
    assign s_wrdata = s_wrdata_q;
    assign s_wren   = s_wren_q;

endmodule

// File: rtl/arc4_encrypt.sv
// arc4_encrypt: single-key ARC4 encryptor. Reads a length-prefixed plaintext
// from PT, schedules S via arc4_ksa, then writes ct[0]=L and ct[k]=pt[k]^pad
// for k=1..L (9 cycles per byte).
// Ports: clk, rst_n (async active-low), en/rdy start handshake, key
// (big-endian, 8*KEY_BYTES), S port s_addr/s_wrdata/s_wren/s_rddata, PT read
// port pt_addr/pt_rddata, CT write port ct_addr/ct_wrdata/ct_wren. Memory
// reads have one cycle of latency after the address is presented.
// Optional build macro ARC4_DROP_EN: discard DROP_N leading keystream bytes
// (RC4-dropN) before the first CT byte; without it DROP_N is ignored.
module arc4_encrypt
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int DROP_N    = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             s_addr,
    output logic [7:0]             s_wrdata,
    output logic                   s_wren,
    input  logic [7:0]             s_rddata,
    output logic [7:0]             pt_addr,
    input  logic [7:0]             pt_rddata,
    output logic [7:0]             ct_addr,
    output logic [7:0]             ct_wrdata,
    output logic                   ct_wren
);

    arc4_state_e state_q, state_d;
    logic [7:0]  i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d, si_q, si_d, sj_q, sj_d;
    logic [7:0]  s_addr_q, s_addr_d, s_wrdata_q, s_wrdata_d, pt_addr_q, pt_addr_d;
    logic [7:0]  ct_addr_q, ct_addr_d, ct_wrdata_q, ct_wrdata_d;
    logic        s_wren_q, s_wren_d, ct_wren_q, ct_wren_d, rdy_q, rdy_d;
    logic        ksa_en_s, ksa_rdy_s, ksa_s_wren_s, ksa_sel_s, drop_active_s;
    logic [7:0]  ksa_s_addr_s, ksa_s_wrdata_s;

`ifdef ARC4_DROP_EN
    localparam logic [15:0] DROP_N_C = 16'(DROP_N);
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        dropping_q, dropping_d;
    assign drop_active_s = dropping_q;
`else
    assign drop_active_s = 1'b0;
`endif

    assign ksa_en_s  = (state_q == ST_IDLE) && en;
    assign ksa_sel_s = (state_q == ST_KSA_RUN);

    arc4_ksa #(.KEY_BYTES(KEY_BYTES)) u_ksa (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (ksa_en_s),
        .rdy      (ksa_rdy_s),
        .key      (key),
        .s_addr   (ksa_s_addr_s),
        .s_wrdata (ksa_s_wrdata_s),
        .s_wren   (ksa_s_wren_s),
        .s_rddata (s_rddata)
    );

    // Top controller: LEN / PRGA / (DROP) / DONE sequencing and port commands.
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        len_d       = len_q;
        si_d        = si_q;
        sj_d        = sj_q;
        pt_addr_d   = pt_addr_q;
        s_addr_d    = 8'h00;
        s_wrdata_d  = 8'h00;
        s_wren_d    = 1'b0;
        ct_addr_d   = 8'h00;
        ct_wrdata_d = 8'h00;
        ct_wren_d   = 1'b0;
`ifdef ARC4_DROP_EN
        drop_cnt_d  = drop_cnt_q;
        dropping_d  = dropping_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_KSA_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_KSA_RUN: begin
                if (ksa_rdy_s) begin
                    state_d = ST_LEN_RD;
                end else begin
                    state_d = ST_KSA_RUN;
                end
            end
            ST_LEN_RD: begin
                pt_addr_d = 8'h00;
                state_d   = ST_LEN_WAIT;
            end
            ST_LEN_WAIT: state_d = ST_LEN_WR;
            ST_LEN_WR: begin
                len_d       = pt_rddata;
                ct_addr_d   = 8'h00;
                ct_wrdata_d = pt_rddata;
                ct_wren_d   = 1'b1;
                i_d         = 8'h00;
                j_d         = 8'h00;
                k_d         = 8'h00;
`ifdef ARC4_DROP_EN
                drop_cnt_d  = 16'h0000;
                dropping_d  = 1'b0;
                state_d     = ST_DROP;
`else
                if (pt_rddata == 8'h00) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_PRGA_RDI;
                end
`endif
            end
`ifdef ARC4_DROP_EN
            ST_DROP: begin
                if (drop_cnt_q == DROP_N_C) begin
                    dropping_d = 1'b0;
                    state_d    = (len_q == 8'h00) ? ST_DONE : ST_PRGA_RDI;
                end else begin
                    dropping_d = 1'b1;
                    drop_cnt_d = drop_cnt_q + 16'd1;
                    state_d    = ST_PRGA_RDI;
                end
            end
`endif
            ST_PRGA_RDI: begin
                i_d      = i_q + 8'd1;
                s_addr_d = i_q + 8'd1;
                // Discarded rounds leave the byte index and PT address alone.
                if (drop_active_s) begin
                    k_d = k_q;
                end else begin
                    k_d       = k_q + 8'd1;
                    pt_addr_d = k_q + 8'd1;
                end
                state_d = ST_PRGA_WAITI;
            end
            ST_PRGA_WAITI: state_d = ST_PRGA_RDJ;
            ST_PRGA_RDJ: begin
                si_d     = s_rddata;
                j_d      = j_q + s_rddata;
                s_addr_d = j_q + s_rddata;
                state_d  = ST_PRGA_WAITJ;
            end
            ST_PRGA_WAITJ: state_d = ST_PRGA_WRI;
            ST_PRGA_WRI: begin
                sj_d       = s_rddata;
                s_addr_d   = i_q;
                s_wrdata_d = s_rddata;
                s_wren_d   = 1'b1;
                state_d    = ST_PRGA_WRJ;
            end
            ST_PRGA_WRJ: begin
                s_addr_d   = j_q;
                s_wrdata_d = si_q;
                s_wren_d   = 1'b1;
                state_d    = ST_PRGA_RDPAD;
            end
            ST_PRGA_RDPAD: begin
                s_addr_d = si_q + sj_q;
                state_d  = ST_PRGA_WAITPAD;
            end
            ST_PRGA_WAITPAD: state_d = ST_PRGA_XOR;
            ST_PRGA_XOR: begin
                if (drop_active_s) begin
                    state_d = ST_DROP;
                end else begin
                    ct_addr_d   = k_q;
                    ct_wrdata_d = pt_rddata ^ s_rddata;
                    ct_wren_d   = 1'b1;
                    state_d     = (k_q == len_q) ? ST_DONE : ST_PRGA_RDI;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        rdy_d = (state_d == ST_IDLE);
    end

    // Controller state and registered memory-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            i_q         <= 8'h00;
            j_q         <= 8'h00;
            k_q         <= 8'h00;
            len_q       <= 8'h00;
            si_q        <= 8'h00;
            sj_q        <= 8'h00;
            s_addr_q    <= 8'h00;
            s_wrdata_q  <= 8'h00;
            s_wren_q    <= 1'b0;
            pt_addr_q   <= 8'h00;
            ct_addr_q   <= 8'h00;
            ct_wrdata_q <= 8'h00;
            ct_wren_q   <= 1'b0;
            rdy_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            len_q       <= len_d;
            si_q        <= si_d;
            sj_q        <= sj_d;
            s_addr_q    <= s_addr_d;
            s_wrdata_q  <= s_wrdata_d;
            s_wren_q    <= s_wren_d;
            pt_addr_q   <= pt_addr_d;
            ct_addr_q   <= ct_addr_d;
            ct_wrdata_q <= ct_wrdata_d;
            ct_wren_q   <= ct_wren_d;
            rdy_q       <= rdy_d;
        end
    end

`ifdef ARC4_DROP_EN
    // Drop-round bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 16'h0000;
            dropping_q <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            dropping_q <= dropping_d;
        end
    end
`endif

    // S port belongs to the key scheduler while it runs.
    assign s_addr    = ksa_sel_s ? ksa_s_addr_s   : s_addr_q;
    assign s_wrdata  = ksa_sel_s ? ksa_s_wrdata_s : s_wrdata_q;
    assign s_wren    = ksa_sel_s ? ksa_s_wren_s   : s_wren_q;
    assign pt_addr   = pt_addr_q;
    assign ct_addr   = ct_addr_q;
    assign ct_wrdata = ct_wrdata_q;
    assign ct_wren   = ct_wren_q;
    assign rdy       = rdy_q;

endmodule

// File: doc/arc4_encrypt.md
Name: arc4_encrypt

Overview:
- Single-key ARC4 encryptor, the transmit-side counterpart of the crack/decrypt path.
- Reads a length-prefixed plaintext message from a PT memory and runs init, KSA and PRGA over an external 256x8 S memory.
- Writes the length-prefixed ciphertext to a CT memory; its output is the CT image the crack path consumes, which enables self-checking round-trip tests on the board.

Parameters:
- KEY_BYTES, 3, key length in bytes; key port width is 8*KEY_BYTES.
- DROP_N, 0, number of leading keystream bytes discarded (used only with ARC4_DROP_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  start request; sampled only while rdy=1
- rdy  out  1  idle/ready
- key  in  8*KEY_BYTES  key; big-endian: key byte k = key[8*(KEY_BYTES-k)-1 -: 8]
- s_addr  out  8  S memory address
- s_wrdata  out  8  S write data
- s_wren  out  1  S write enable
- s_rddata  in  8  S read data, valid 1 cycle after s_addr is presented
- pt_addr  out  8  PT read address
- pt_rddata  in  8  PT read data, 1-cycle latency
- ct_addr  out  8  CT write address
- ct_wrdata  out  8  CT write data
- ct_wren  out  1  CT write enable

Behaviour:
- Reset (asynchronous, rst_n=0): rdy=1; all addresses, write data and write enables = 0; i=j=0; FSM=IDLE. Reset mid-operation aborts immediately; memory contents are left undefined; the next en restarts from INIT.
- Handshake: en && rdy starts a run and latches key. rdy drops the next cycle and returns to 1 the cycle after the last CT write. en is ignored while rdy=0.
- States: IDLE -> INIT -> KSA -> LEN -> PRGA -> (DROP if ARC4_DROP_EN) -> DONE -> IDLE.
- INIT: 256 cycles; writes s[i]=i for i=0..255.
- KSA, i=0..255:
  - read s[i]; wait;
  - j = j + s[i] + key[i mod KEY_BYTES] (mod 256);
  - read s[j]; wait;
  - write s[i]=old s[j]; write s[j]=old s[i].
  - Fixed 6 cycles per i; the i==j case writes the same value twice.
- LEN: read pt[0] to get L. Write ct[0]=L. Reset i=j=0.
- PRGA, k=1..L:
  - i=i+1;
  - read s[i]; j=j+s[i];
  - read s[j]; swap;
  - read s[(s[i]+s[j]) mod 256] = pad;
  - read pt[k];
  - write ct[k]=pt[k]^pad.
  - Fixed 9 cycles per byte; the pt read overlaps the S reads.
- L=0: no PRGA iterations; go to DONE after the ct[0] write.
- L=255: k wraps naturally and reaches 255 exactly. All index arithmetic is 8-bit, modulo 256.
- At most one S access per cycle. s_wren and ct_wren are never asserted in the same cycle as a read that depends on them.
- DONE: 1 cycle, then rdy=1.

Optional Feature:
- Macro: ARC4_DROP_EN.
- Defined: before the first CT byte, DROP_N full PRGA rounds run with the CT write suppressed (RC4-dropN). i/j/S state carries over into the real PRGA.
- Undefined: no DROP state and no drop counter logic; DROP_N is ignored. Output is bit-identical to the defined build with DROP_N=0.

Decomposition:
- Package arc4_pkg holds:
  - state enum (IDLE, INIT, KSA_*, LEN, PRGA_*, DROP, DONE);
  - constants S_DEPTH=256 and KSA_CYCLES_PER_I=6;
  - a function keybyte(key, idx).
- Shared with the decrypt path.
- One sub-module is natural: arc4_ksa (init+KSA, own en/rdy). The top FSM then handles LEN/PRGA/DONE and muxes the S port by phase.

Test Plan:
- Vector: key=24'h4B6579 ("Key"), pt = 09 50 6C 61 69 6E 74 65 78 74 ("Plaintext") -> ct = 09 BB F3 16 E8 D9 40 AF 0A D3; rdy returns high.
- Zero length: pt[0]=00, any key -> ct[0]=00; no other CT writes; rdy returns after INIT+KSA+LEN+DONE.
- Round trip: encrypt 255 random bytes with key 24'h000018, feed CT into the crack/decrypt block -> key_valid=1, key=000018, recovered pt matches the original.
- Handshake: pulse en while rdy=0 mid-KSA -> ignored, single run only, output unchanged; back-to-back runs with keys A then B -> second CT matches the model for key B.
- Reset: drop rst_n during PRGA -> rdy=1, ct_wren=0 in the same cycle; a new en yields correct CT.
- ARC4_DROP_EN, DROP_N=0 -> output identical to the first vector; DROP_N=3 -> output matches a reference model with 3 discarded keystream bytes.
